// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared constants for the registered 2-to-4 decoder and its
//               2-entry skid buffer (default widths, state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int IN_W_DEF  = 2;
    localparam int CNT_W_DEF = 8;
    localparam int OUT_W     = 2 ** IN_W_DEF;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/skid_buffer_2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer_2
// Description : Generic-width 2-entry valid/ready skid buffer. Output and
//               in_ready are taken straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer_2
    import decoder_pkg::*;
#(
    parameter int WIDTH = OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             w_push;
    logic             w_pop;

    assign w_push = in_valid_i && ready_q;
    assign w_pop  = valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    main_d  = in_data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    main_d = in_data_i;
                end else if (w_push) begin
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (w_pop) begin
                    // Clearing main keeps the data output zero while idle.
                    main_d  = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = ST_EMPTY;
            end
        endcase
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;

endmodule : skid_buffer_2
`default_nettype wire

// File: rtl/decoder_2a4_skid.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2a4_skid
// Description : Registered 2-to-4 decoder behind a 2-entry skid buffer, with a
//               saturating counter of discarded v=0 words.
//               Optional macro DECODER_ZERO_PASS_EN: v=0 words pass through as
//               an all-zero vector and drop_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_2a4_skid
    import decoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_v,
    input  logic [IN_W-1:0]      in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_x,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int W_X = 2 ** IN_W;

    logic [W_X-1:0] w_onehot;
    logic [W_X-1:0] w_enq_data;
    logic           w_enq_valid;

    assign w_onehot = {{(W_X-1){1'b0}}, 1'b1} << in_y;

`ifdef DECODER_ZERO_PASS_EN
    assign w_enq_valid = in_valid;
    assign w_enq_data  = in_v ? w_onehot : '0;
    assign drop_cnt    = '0;
`else
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_drop;

    assign w_enq_valid = in_valid && in_v;
    assign w_enq_data  = w_onehot;
    // A v=0 word still consumes the handshake, so it only counts when accepted.
    assign w_drop      = in_valid && in_ready && !in_v;

    always_comb begin
        cnt_d = cnt_q;
        if (w_drop && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;
`endif

    skid_buffer_2 #(
        .WIDTH (W_X)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (w_enq_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (w_enq_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_x)
    );

endmodule : decoder_2a4_skid
`default_nettype wire
